mem_stage_ctrl: RTL

Memory-stage controller between the EX/MEM pipeline register and a multi-cycle data memory. It takes a load or store from the pipeline, runs a req/ack handshake with the memory, and drives `hold` to freeze the pipeline until the access completes. It then presents the load word as four bytes on `data_out[0:3]`, which feeds the MEM/WB register's `data_out` and `hold` inputs directly.

---
 rtl/mem_stage_ctrl_if.sv | 20 ++
 rtl/mem_stage_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Memory-side req/ack bus between the MEM-stage controller (master) and a multi-cycle data memory (slave).
interface mem_stage_ctrl_if;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_be;
  logic [0:3][7:0]  mem_wdata;
  logic [0:3][7:0]  mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: one load/store per req/ack handshake; minimum 3 cycles (request, ack, release).
// Backpressure: hold_o freezes the pipeline from the request cycle until DONE; a missing ack aborts after TIMEOUT cycles.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memread_i,
  input  logic             memwrite_i,
  input  logic [31:0]      addr_i,
  input  logic [0:3][7:0]  wdata_i,
  input  logic [3:0]       be_i,
  output logic             hold_o,
  output logic [0:3][7:0]  data_out_o,
  output logic             err_o,
  mem_stage_ctrl_if.master mem
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [0:3][7:0]  mem_wdata_q;
  logic [0:3][7:0]  data_out_q;
  logic             err_q;
  logic             req_any;
  logic             unused_addr_bits;

  assign req_any = memread_i | memwrite_i;

  // Memory is word-addressed; the byte offset only matters to the byte enables.
  assign unused_addr_bits = ^addr_i[1:0];

  // Combinational so the stall reaches MEM/WB in the same cycle the request shows up.
  assign hold_o = (state_q == S_WAIT) || ((state_q == S_IDLE) && req_any);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      data_out_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            mem_addr_q  <= {addr_i[31:2], 2'b00};
            mem_we_q    <= memwrite_i;
            mem_be_q    <= memwrite_i ? be_i : 4'b1111;
            mem_wdata_q <= wdata_i;
            mem_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              data_out_q <= mem.mem_rdata;
            end
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: release the pipeline with a zeroed load and a sticky error.
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (!mem_we_q) begin
              data_out_q <= '0;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign data_out_o    = data_out_q;
  assign err_o         = err_q;

endmodule
